serial_deser: RTL

//  Serial-to-parallel receiver: the far end of the parallel-load shift-register transmitter in shizhong_demo.

---
 rtl/serial_deser.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/serial_deser.sv
`default_nettype none
// ============================================================================
// serial_deser : framed serial-to-parallel receiver, one-deep valid/ready out.
// Optional per-word even parity bit when DESER_PARITY_EN is defined.
// Rev 1.0
// ============================================================================
module serial_deser #(
  parameter string DIRECTION = "LEFT",
  parameter int    WIDTH     = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_i,
  input  logic             bit_vld_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o,
  output logic             data_vld_o,
  input  logic             data_rdy_i,
  output logic             busy_o,
  output logic             overflow_o,
  output logic             frame_err_o,
  output logic             parity_err_o
);

`ifdef DESER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int N  = WIDTH + PAR;
  localparam int CW = $clog2(N);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             sample, last, par_slot, par_ok, word_done;

  generate
    if (DIRECTION == "RIGHT") begin : g_right
      assign shifted = {bit_i, sr_q[WIDTH-1:1]};
    end else begin : g_left
      assign shifted = {sr_q[WIDTH-2:0], bit_i};
    end
  endgenerate

  // With parity the data bits are already in sr_q when the parity bit arrives.
`ifdef DESER_PARITY_EN
  assign par_slot = (cnt_q == CW'(WIDTH));
  assign par_ok   = ~(^sr_q ^ bit_i);
  assign word     = sr_q;
`else
  assign par_slot = 1'b0;
  assign par_ok   = 1'b1;
  assign word     = shifted;
`endif

  assign sample    = frame_i & bit_vld_i;
  assign last      = (cnt_q == CW'(N - 1));
  assign word_done = sample & last & par_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    data_d  = data_q;
    vld_d   = vld_q;
    ovf_d   = ovf_q;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;

    case (state_q)
      S_IDLE:  if (frame_i)  state_d = S_SHIFT;
      S_SHIFT: if (!frame_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (!frame_i) begin
      ferr_d = (cnt_q != '0);
      cnt_d  = '0;
      sr_d   = '0;
    end else if (bit_vld_i) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
      if (!par_slot) sr_d = shifted;
      perr_d = last & ~par_ok;
    end

    if (vld_q && data_rdy_i) vld_d = 1'b0;
    if (word_done) begin
      if (!vld_q || data_rdy_i) begin
        data_d = word;
        vld_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  assign data_o       = data_q;
  assign data_vld_o   = vld_q;
  assign busy_o       = busy_q;
  assign overflow_o   = ovf_q;
  assign frame_err_o  = ferr_q;
  assign parity_err_o = perr_q;

endmodule
`default_nettype wire
